// File: rtl/raster_scan_pkg.sv
// Shared types and constants for the raster_scan traversal block.
// Contents:
//   COORD_W / WEIGHT_W   coordinate and barycentric weight widths
//   SCREEN_W / SCREEN_H  default screen size used by the clamp
//   scan_state_t         traversal FSM states
//   vertex_t, fragment_t packed bundles moved around the datapath
//   min2 / max2          unsigned coordinate helpers for the bounding box
package raster_pkg;

  localparam int COORD_W  = 10;
  localparam int WEIGHT_W = 20;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SCAN,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [WEIGHT_W-1:0] u;
    logic [WEIGHT_W-1:0] v;
    logic [WEIGHT_W-1:0] w;
    logic [WEIGHT_W-1:0] a;
  } fragment_t;

  function automatic logic [COORD_W-1:0] min2(input logic [COORD_W-1:0] p,
                                              input logic [COORD_W-1:0] q);
    return (p < q) ? p : q;
  endfunction

  function automatic logic [COORD_W-1:0] max2(input logic [COORD_W-1:0] p,
                                              input logic [COORD_W-1:0] q);
    return (p > q) ? p : q;
  endfunction

endpackage

// File: rtl/raster_scan_if.sv
// Bus bundle around raster_scan.
//   tri_*   : triangle input handshake (tri_valid/tri_ready + six vertex coords)
//   ras_*   : vertices and current pixel out to the rasterizer, weights and
//             coverage back from it (combinational in the same cycle)
//   frag_*  : registered fragment output with valid/ready backpressure
//   tri_done: one-cycle pulse at the end of each triangle
// Modport slave is the traversal block, master is its environment.
interface raster_scan_if;
  import raster_pkg::*;

  logic                tri_valid;
  logic                tri_ready;
  logic [COORD_W-1:0]  tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy;

  logic [COORD_W-1:0]  ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy;
  logic [COORD_W-1:0]  ras_x, ras_y;
  logic [WEIGHT_W-1:0] ras_ua, ras_va, ras_wa, ras_a;
  logic                ras_visible;

  logic                frag_valid;
  logic                frag_ready;
  logic [COORD_W-1:0]  frag_x, frag_y;
  logic [WEIGHT_W-1:0] frag_u, frag_v, frag_w, frag_a;

  logic                tri_done;

  modport slave (
    input  tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy,
    output tri_ready,
    output ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy, ras_x, ras_y,
    input  ras_ua, ras_va, ras_wa, ras_a, ras_visible,
    output frag_valid, frag_x, frag_y, frag_u, frag_v, frag_w, frag_a,
    input  frag_ready,
    output tri_done
  );

  modport master (
    output tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy,
    input  tri_ready,
    input  ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy, ras_x, ras_y,
    output ras_ua, ras_va, ras_wa, ras_a, ras_visible,
    input  frag_valid, frag_x, frag_y, frag_u, frag_v, frag_w, frag_a,
    output frag_ready,
    input  tri_done
  );

endinterface

// File: rtl/raster_scan_bbox_setup.sv
// bbox_setup: combinational screen-clamped bounding box of three vertices.
// Ports:
//   va, vb, vc        : triangle vertices (unsigned screen coordinates)
//   xmin, ymin        : smallest coordinate per axis (not clamped)
//   xmax, ymax        : largest coordinate per axis, clamped to the last
//                       column / row of the screen
//   offscreen         : the box starts beyond the screen on either axis
module bbox_setup
  import raster_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H
) (
  input  vertex_t            va,
  input  vertex_t            vb,
  input  vertex_t            vc,
  output logic [COORD_W-1:0] xmin,
  output logic [COORD_W-1:0] xmax,
  output logic [COORD_W-1:0] ymin,
  output logic [COORD_W-1:0] ymax,
  output logic               offscreen
);

  // Index 0 is the x axis, index 1 the y axis.
  logic [1:0][COORD_W-1:0] lo;
  logic [1:0][COORD_W-1:0] hi;
  logic [1:0]              off;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic [COORD_W-1:0] LAST = COORD_W'((gi == 0) ? WIDTH - 1 : HEIGHT - 1);
      logic [COORD_W-1:0] p0, p1, p2, top;

      assign p0  = (gi == 0) ? va.x : va.y;
      assign p1  = (gi == 0) ? vb.x : vb.y;
      assign p2  = (gi == 0) ? vc.x : vc.y;
      assign top = max2(max2(p0, p1), p2);

      assign lo[gi]  = min2(min2(p0, p1), p2);
      assign hi[gi]  = min2(top, LAST);
      // Only the minimum can place the whole box past the screen edge;
      // the maximum is simply clamped.
      assign off[gi] = (lo[gi] > LAST);
    end
  endgenerate

  assign xmin      = lo[0];
  assign xmax      = hi[0];
  assign ymin      = lo[1];
  assign ymax      = hi[1];
  assign offscreen = |off;

endmodule

// File: rtl/raster_scan.sv
// raster_scan: triangle traversal stage in front of the edge-function
// rasterizer. Accepts a triangle, computes its clamped bounding box, walks the
// box row-major one pixel per cycle and registers every covered pixel (with
// its barycentric weights) as a fragment.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : raster_scan_if.slave (triangle in, rasterizer link, fragments out)
module raster_scan
  import raster_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H
) (
  input  logic          clk,
  input  logic          rst,
  raster_scan_if.slave  bus
);

  scan_state_t        state_reg, state_next;
  vertex_t            va_reg, vb_reg, vc_reg, va_next, vb_next, vc_next;
  logic [COORD_W-1:0] x_reg, y_reg, x_next, y_next;
  logic [COORD_W-1:0] xmin_reg, xmax_reg, ymax_reg;
  logic [COORD_W-1:0] xmin_next, xmax_next, ymax_next;
  fragment_t          frag_reg, frag_next;
  logic               frag_valid_reg, frag_valid_next;

  logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic               bb_offscreen;
  logic               slot_free;

  bbox_setup #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_bbox (
    .va       (va_reg),
    .vb       (vb_reg),
    .vc       (vc_reg),
    .xmin     (bb_xmin),
    .xmax     (bb_xmax),
    .ymin     (bb_ymin),
    .ymax     (bb_ymax),
    .offscreen(bb_offscreen)
  );

  // The fragment register can take a new value when empty or being drained.
  assign slot_free = !frag_valid_reg || bus.frag_ready;

  always_comb begin
    state_next      = state_reg;
    va_next         = va_reg;
    vb_next         = vb_reg;
    vc_next         = vc_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    xmin_next       = xmin_reg;
    xmax_next       = xmax_reg;
    ymax_next       = ymax_reg;
    frag_next       = frag_reg;
    frag_valid_next = frag_valid_reg;

    // A held fragment drains whenever the consumer is ready; SCAN overrides.
    if (bus.frag_ready) begin
      frag_valid_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        if (bus.tri_valid) begin
          va_next    = '{x: bus.tri_ax, y: bus.tri_ay};
          vb_next    = '{x: bus.tri_bx, y: bus.tri_by};
          vc_next    = '{x: bus.tri_cx, y: bus.tri_cy};
          state_next = SETUP;
        end
      end
      SETUP: begin
        xmin_next = bb_xmin;
        xmax_next = bb_xmax;
        ymax_next = bb_ymax;
        if (bb_offscreen) begin
          state_next = DONE;
        end else begin
          x_next     = bb_xmin;
          y_next     = bb_ymin;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (slot_free) begin
          if (bus.ras_visible) begin
            frag_next = '{x: x_reg, y: y_reg, u: bus.ras_ua, v: bus.ras_va,
                          w: bus.ras_wa, a: bus.ras_a};
            frag_valid_next = 1'b1;
          end else begin
            frag_valid_next = 1'b0;
          end
          if (x_reg < xmax_reg) begin
            x_next = x_reg + 1'b1;
          end else begin
            x_next = xmin_reg;
            y_next = y_reg + 1'b1;
            if (y_reg == ymax_reg) begin
              state_next = DONE;
            end
          end
        end else begin
          // Stall: the pending fragment must not be overwritten.
          frag_valid_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      va_reg         <= '0;
      vb_reg         <= '0;
      vc_reg         <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      xmin_reg       <= '0;
      xmax_reg       <= '0;
      ymax_reg       <= '0;
      frag_reg       <= '0;
      frag_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      va_reg         <= va_next;
      vb_reg         <= vb_next;
      vc_reg         <= vc_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      xmin_reg       <= xmin_next;
      xmax_reg       <= xmax_next;
      ymax_reg       <= ymax_next;
      frag_reg       <= frag_next;
      frag_valid_reg <= frag_valid_next;
    end
  end

  assign bus.tri_ready  = (state_reg == IDLE);
  assign bus.tri_done   = (state_reg == DONE);

  assign bus.ras_ax     = va_reg.x;
  assign bus.ras_ay     = va_reg.y;
  assign bus.ras_bx     = vb_reg.x;
  assign bus.ras_by     = vb_reg.y;
  assign bus.ras_cx     = vc_reg.x;
  assign bus.ras_cy     = vc_reg.y;
  assign bus.ras_x      = x_reg;
  assign bus.ras_y      = y_reg;

  assign bus.frag_valid = frag_valid_reg;
  assign bus.frag_x     = frag_reg.x;
  assign bus.frag_y     = frag_reg.y;
  assign bus.frag_u     = frag_reg.u;
  assign bus.frag_v     = frag_reg.v;
  assign bus.frag_w     = frag_reg.w;
  assign bus.frag_a     = frag_reg.a;

endmodule

// File: tb/tb_raster_scan.sv
// Bench for raster_scan: an edge-function rasterizer model closes the loop,
// a reference enumerates the clamped box row-major and queues the expected
// fragments, and a monitor pops and compares on every fragment handshake.
module tb_raster_scan;
  import raster_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  raster_scan_if bus();

  raster_scan #(.WIDTH(640), .HEIGHT(480)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int x, y, u, v, w, a;
  } frag_exp_t;

  frag_exp_t exp_q[$];
  int acc_cnt    = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int ready_mode = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Edge function of edge (p0 -> p1) evaluated at p.
  function automatic int edgef(input int x0, input int y0, input int x1, input int y1,
                               input int px, input int py);
    return (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
  endfunction

  function automatic bit covered(input int u, input int v, input int w, input int a);
    return (a > 0 && u >= 0 && v >= 0 && w >= 0) || (a < 0 && u <= 0 && v <= 0 && w <= 0);
  endfunction

  // Rasterizer model: combinational from the block's vertex/pixel registers.
  int r_ua, r_va, r_wa, r_a;
  assign r_ua = edgef(int'(bus.ras_bx), int'(bus.ras_by), int'(bus.ras_cx), int'(bus.ras_cy),
                      int'(bus.ras_x), int'(bus.ras_y));
  assign r_va = edgef(int'(bus.ras_cx), int'(bus.ras_cy), int'(bus.ras_ax), int'(bus.ras_ay),
                      int'(bus.ras_x), int'(bus.ras_y));
  assign r_wa = edgef(int'(bus.ras_ax), int'(bus.ras_ay), int'(bus.ras_bx), int'(bus.ras_by),
                      int'(bus.ras_x), int'(bus.ras_y));
  assign r_a  = edgef(int'(bus.ras_ax), int'(bus.ras_ay), int'(bus.ras_bx), int'(bus.ras_by),
                      int'(bus.ras_cx), int'(bus.ras_cy));
  assign bus.ras_ua      = r_ua[19:0];
  assign bus.ras_va      = r_va[19:0];
  assign bus.ras_wa      = r_wa[19:0];
  assign bus.ras_a       = r_a[19:0];
  assign bus.ras_visible = covered(r_ua, r_va, r_wa, r_a);

  // Reference: clamped box, row-major walk, queue every covered pixel.
  task automatic ref_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, output int npix, output int nfrag);
    int xlo, xhi, ylo, yhi;
    frag_exp_t f;
    xlo = ax; if (bx < xlo) xlo = bx; if (cx < xlo) xlo = cx;
    ylo = ay; if (by < ylo) ylo = by; if (cy < ylo) ylo = cy;
    xhi = ax; if (bx > xhi) xhi = bx; if (cx > xhi) xhi = cx;
    yhi = ay; if (by > yhi) yhi = by; if (cy > yhi) yhi = cy;
    if (xhi > SCREEN_W - 1) xhi = SCREEN_W - 1;
    if (yhi > SCREEN_H - 1) yhi = SCREEN_H - 1;
    npix  = 0;
    nfrag = 0;
    if (xlo > SCREEN_W - 1 || ylo > SCREEN_H - 1) return;
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        npix++;
        f.x = x;
        f.y = y;
        f.u = edgef(bx, by, cx, cy, x, y);
        f.v = edgef(cx, cy, ax, ay, x, y);
        f.w = edgef(ax, ay, bx, by, x, y);
        f.a = edgef(ax, ay, bx, by, cx, cy);
        if (covered(f.u, f.v, f.w, f.a)) begin
          exp_q.push_back(f);
          nfrag++;
        end
      end
    end
  endtask

  // Monitor: scoreboard pop on handshake, hold-stability while stalled,
  // tri_done bookkeeping.
  logic [99:0] held;
  bit          hold_pending = 1'b0;
  initial begin
    frag_exp_t f;
    logic [99:0] cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        cur = {bus.frag_x, bus.frag_y, bus.frag_u, bus.frag_v, bus.frag_w, bus.frag_a};
        if (hold_pending) begin
          check("stall_valid", bus.frag_valid, 1);
          check("stall_hold", (cur == held) ? 1 : 0, 1);
        end
        hold_pending = bus.frag_valid && !bus.frag_ready;
        held = cur;
        if (bus.frag_valid && bus.frag_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frag: got (%0d,%0d), required none", bus.frag_x, bus.frag_y);
          end else begin
            f = exp_q.pop_front();
            check("frag_x", bus.frag_x, f.x);
            check("frag_y", bus.frag_y, f.y);
            check("frag_u", bus.frag_u, longint'(f.u) & 64'hFFFFF);
            check("frag_v", bus.frag_v, longint'(f.v) & 64'hFFFFF);
            check("frag_w", bus.frag_w, longint'(f.w) & 64'hFFFFF);
            check("frag_a", bus.frag_a, longint'(f.a) & 64'hFFFFF);
          end
        end
        if (bus.tri_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // Consumer backpressure: 0 always ready, 1 toggling, 2 random.
  initial begin
    bus.frag_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.frag_ready = ~bus.frag_ready;
        2:       bus.frag_ready = ($urandom_range(0, 3) != 0);
        default: bus.frag_ready = 1'b1;
      endcase
    end
  end

  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, output int t_hs);
    int guard;
    @(negedge clk);
    bus.tri_ax = 10'(ax); bus.tri_ay = 10'(ay);
    bus.tri_bx = 10'(bx); bus.tri_by = 10'(by);
    bus.tri_cx = 10'(cx); bus.tri_cy = 10'(cy);
    bus.tri_valid = 1'b1;
    guard = 0;
    while (!bus.tri_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("tri_accept", bus.tri_ready, 1);
    t_hs = cyc;
    @(negedge clk);
    bus.tri_valid = 1'b0;
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input bit timed);
    int d0, a0, npix, nfrag, t_hs, guard;
    d0 = done_cnt;
    a0 = acc_cnt;
    ref_tri(ax, ay, bx, by, cx, cy, npix, nfrag);
    send_tri(ax, ay, bx, by, cx, cy, t_hs);
    guard = 0;
    while (done_cnt == d0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (timed) check("done_cycle", done_cyc, t_hs + 2 + npix);
    while (cyc < done_cyc + 1) @(negedge clk);
    check("ready_after_done", bus.tri_ready, 1);
    guard = 0;
    while ((exp_q.size() != 0 || bus.frag_valid) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("frag_count", acc_cnt - a0, nfrag);
    check("done_pulses", done_cnt - d0, 1);
    $display("tri (%0d,%0d)(%0d,%0d)(%0d,%0d): %0d pixels, %0d fragments, handshake %0d, done %0d",
             ax, ay, bx, by, cx, cy, npix, acc_cnt - a0, t_hs, done_cyc);
  endtask

  initial begin
    int npix, nfrag, t_hs, a0, guard, bx0, by0;
    bus.tri_valid = 1'b0;
    bus.tri_ax = '0; bus.tri_ay = '0; bus.tri_bx = '0;
    bus.tri_by = '0; bus.tri_cx = '0; bus.tri_cy = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tri_ready", bus.tri_ready, 1);
    check("reset_frag_valid", bus.frag_valid, 0);
    check("reset_tri_done", bus.tri_done, 0);
    check("reset_ras_x", bus.ras_x, 0);
    check("reset_ras_y", bus.ras_y, 0);
    check("reset_ras_ax", bus.ras_ax, 0);
    check("reset_frag_x", bus.frag_x, 0);
    check("reset_frag_u", bus.frag_u, 0);

    ready_mode = 0;
    run_tri(0, 0, 4, 0, 0, 4, 1'b1);          // 15 fragments, done at T+27
    run_tri(0, 0, 2, 2, 4, 4, 1'b1);          // collinear: 25 pixels, none covered
    run_tri(700, 10, 710, 10, 700, 20, 1'b1); // offscreen: done at T+2
    run_tri(630, 0, 700, 0, 630, 5, 1'b1);    // clamped to x 630..639
    run_tri(5, 7, 5, 7, 5, 7, 1'b1);          // single-pixel box

    ready_mode = 1;
    run_tri(0, 0, 4, 0, 0, 4, 1'b0);          // toggling backpressure

    // Reset in the middle of a scan, after three fragments.
    ready_mode = 0;
    @(negedge clk);
    a0 = acc_cnt;
    ref_tri(0, 0, 4, 0, 0, 4, npix, nfrag);
    send_tri(0, 0, 4, 0, 0, 4, t_hs);
    guard = 0;
    while (acc_cnt - a0 < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("pre_reset_frags", acc_cnt - a0, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_frag_valid", bus.frag_valid, 0);
    check("midreset_tri_ready", bus.tri_ready, 1);
    check("midreset_tri_done", bus.tri_done, 0);
    $display("reset after %0d fragments of tri (0,0)(4,0)(0,4)", acc_cnt - a0);
    run_tri(1, 1, 6, 2, 2, 5, 1'b1);          // accepted normally afterwards

    for (int i = 0; i < 20; i++) begin
      ready_mode = (i % 2 == 0) ? 0 : 2;
      bx0 = $urandom_range(0, 660);
      by0 = $urandom_range(0, 500);
      run_tri(bx0 + $urandom_range(0, 10), by0 + $urandom_range(0, 10),
              bx0 + $urandom_range(0, 10), by0 + $urandom_range(0, 10),
              bx0 + $urandom_range(0, 10), by0 + $urandom_range(0, 10),
              ready_mode == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/raster_scan.md
Name: raster_scan

Overview:
- Triangle traversal stage directly upstream of the combinational edge-function rasterizer.
- Accepts one triangle (three 10-bit screen-space vertices) over a valid/ready handshake.
- Computes its screen-clamped bounding box and walks it row-major, one pixel per cycle, presenting vertices and the current (x, y) to the rasterizer.
- Captures each pixel the rasterizer reports visible, with its barycentric weights, into a registered fragment output with valid/ready backpressure.

Parameters:
- WIDTH, 640, screen width in pixels; x is clamped to WIDTH-1.
- HEIGHT, 480, screen height in pixels; y is clamped to HEIGHT-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tri_valid  in  1  triangle offered
- tri_ready  out  1  block can accept a triangle
- tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy  in  10 each  vertex coordinates
- ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy  out  10 each  latched vertices to rasterizer
- ras_x, ras_y  out  10 each  current pixel to rasterizer
- ras_ua, ras_va, ras_wa, ras_a  in  20 each  rasterizer weights and area
- ras_visible  in  1  rasterizer coverage result
- frag_valid  out  1  fragment available
- frag_ready  in  1  consumer accepts fragment
- frag_x, frag_y  out  10 each  fragment pixel
- frag_u, frag_v, frag_w, frag_a  out  20 each  captured ua/va/wa/a
- tri_done  out  1  one-cycle pulse when traversal of the current triangle finishes

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - tri_ready = 1; frag_valid = 0; tri_done = 0.
  - All coordinate, pixel and fragment registers are 0.
- States: IDLE, SETUP, SCAN, DONE.
- IDLE:
  - tri_ready = 1.
  - On tri_valid && tri_ready, latch the six vertex coordinates into the ras_* registers and go to SETUP.
- SETUP (1 cycle):
  - xmin = min(ax, bx, cx); xmax = min(max(ax, bx, cx), WIDTH-1).
  - ymin = min(ay, by, cy); ymax = min(max(ay, by, cy), HEIGHT-1).
  - Comparisons are unsigned 10-bit.
  - If xmin > WIDTH-1 or ymin > HEIGHT-1, the triangle is fully offscreen: go to DONE.
  - Otherwise ras_x = xmin, ras_y = ymin, go to SCAN.
- SCAN:
  - ras_x/ras_y are registers; the rasterizer result is combinational in the same cycle.
  - slot_free = !frag_valid || frag_ready.
  - If slot_free:
    - If ras_visible, load frag_x/y = ras_x/y and frag_u/v/w/a = ras_ua/va/wa/a, and set frag_valid = 1.
    - If not visible, frag_valid is cleared when frag_ready is high.
    - Then advance: if ras_x < xmax, increment ras_x. Otherwise set ras_x = xmin and increment ras_y. If also ras_y == ymax, go to DONE.
  - If !slot_free: hold the pixel and all fragment registers (stall).
- DONE (1 cycle):
  - tri_done = 1, then return to IDLE.
  - A pending fragment keeps frag_valid until it is accepted.
- Outside SCAN, frag_valid clears on frag_ready.
- tri_ready is 0 in SETUP, SCAN and DONE.
- Latency:
  - Handshake at cycle T; SETUP at T+1; first pixel evaluated at T+2.
  - First fragment visible at T+3.
  - An unstalled box of N pixels reaches DONE at T+2+N.
- Degenerate triangle (a == 0): the rasterizer reports no coverage; full box is scanned; zero fragments; tri_done still pulses.
- Single-pixel box (xmin == xmax, ymin == ymax): exactly one SCAN cycle.
- Fragment order is strictly row-major, y outer, x inner.
- Reset mid-traversal returns to IDLE next cycle with frag_valid = 0; the pending fragment is dropped.

Decomposition:
- Shared package `raster_pkg`:
  - COORD_W = 10, WEIGHT_W = 20, SCREEN_W = 640, SCREEN_H = 480.
  - Enum scan_state_t {IDLE, SETUP, SCAN, DONE}.
  - Packed struct vertex_t {x, y}.
  - Packed struct fragment_t {x, y, u, v, w, a}.
- One natural sub-module: `bbox_setup` (combinational min/max/clamp/offscreen of three vertices), used only by SETUP.

Test Plan:
- Tri (0,0),(4,0),(0,4), frag_ready = 1:
  - Exactly 15 fragments, those with x+y <= 4, row-major.
  - First fragment (0,0) with u = 16, v = 0, w = 0, a = 16.
  - tri_done at T+27.
- Collinear tri (0,0),(2,2),(4,4):
  - 25 SCAN cycles, zero fragments, one tri_done pulse.
- All vertices at x >= 640, e.g. (700,10),(710,10),(700,20):
  - No fragments; tri_done at T+2; tri_ready back at T+3.
- Tri (630,0),(700,0),(630,5):
  - Scan clamps to x 630..639.
  - No fragment with frag_x > 639.
- First tri above with frag_ready toggling 1/0 every cycle:
  - Same 15 fragments, same order, each held stable while frag_ready = 0.
  - No fragment is lost or duplicated.
- Assert rst during SCAN after 3 fragments:
  - Next cycle state is IDLE, frag_valid = 0, tri_ready = 1.
  - A new triangle is then accepted normally.
